// File: rtl/multicycle_ctrl_if.sv
// Memory handshake between the multicycle controller and the memory system.
// The controller drives the request side and memory returns completion.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I-subset datapath: FETCH/DECODE/EXEC/MEM/WB
// with a sticky TRAP state for unsupported opcodes and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          ir,
    input  logic                 br_taken,
    multicycle_ctrl_if.master    bus,
    output logic                 ir_we,
    output logic                 mdr_we,
    output logic                 pc_we,
    output logic                 reg_we,
    output logic                 pc_src,
    output logic [1:0]           alu_src_a,
    output logic                 alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           wb_sel,
    output logic [2:0]           state,
    output logic                 illegal,
    output logic                 instr_done,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t     state_q;
    state_t     next_state;
    logic [6:0] opcode;
    logic       supported;
    logic       unused_ir;

    assign opcode    = ir[6:0];
    assign unused_ir = ^ir[31:7];
    assign state     = state_q;

    always_comb begin
        supported = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_LUI, OP_AUIPC, OP_JAL: supported = 1'b1;
            default: supported = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= next_state;
    end

    always_comb begin
        next_state   = state_q;
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.addr_sel = 1'b0;
        ir_we        = 1'b0;
        mdr_we       = 1'b0;
        pc_we        = 1'b0;
        reg_we       = 1'b0;
        pc_src       = 1'b0;
        alu_src_a    = 2'd0;
        alu_src_b    = 1'b0;
        alu_op       = 2'd0;
        wb_sel       = 2'd0;
        illegal      = 1'b0;
        instr_done   = 1'b0;

        case (state_q)
            FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_we      = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: next_state = supported ? EXEC : TRAP;
            EXEC: begin
                case (opcode)
                    OP_R: begin
                        alu_op     = 2'd1;
                        next_state = WB;
                    end
                    OP_I: begin
                        alu_src_b  = 1'b1;
                        alu_op     = 2'd1;
                        next_state = WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b  = 1'b1;
                        next_state = MEM;
                    end
                    OP_BR: begin
                        alu_op     = 2'd2;
                        pc_we      = 1'b1;
                        pc_src     = br_taken;
                        instr_done = 1'b1;
                        next_state = FETCH;
                    end
                    OP_LUI: begin
                        alu_src_a  = 2'd2;
                        alu_src_b  = 1'b1;
                        next_state = WB;
                    end
                    OP_AUIPC: begin
                        alu_src_a  = 2'd1;
                        alu_src_b  = 1'b1;
                        next_state = WB;
                    end
                    OP_JAL: begin
                        reg_we     = 1'b1;
                        wb_sel     = 2'd2;
                        pc_we      = 1'b1;
                        pc_src     = 1'b1;
                        instr_done = 1'b1;
                        next_state = FETCH;
                    end
                    default: next_state = TRAP;
                endcase
            end
            MEM: begin
                // Request lines depend only on state and opcode, so they stay stable across waits
                bus.mem_req  = 1'b1;
                bus.addr_sel = 1'b1;
                bus.mem_we   = (opcode == OP_SW);
                if (bus.mem_ready) begin
                    if (opcode == OP_SW) begin
                        pc_we      = 1'b1;
                        instr_done = 1'b1;
                        next_state = FETCH;
                    end else begin
                        mdr_we     = 1'b1;
                        next_state = WB;
                    end
                end
            end
            WB: begin
                reg_we     = 1'b1;
                wb_sel     = (opcode == OP_LW) ? 2'd1 : 2'd0;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            TRAP: illegal = 1'b1;
            default: next_state = FETCH;
        endcase

        // Reset must silence the memory port and all enables even between clock edges
        if (rst) begin
            bus.mem_req  = 1'b0;
            bus.mem_we   = 1'b0;
            bus.addr_sel = 1'b0;
            ir_we        = 1'b0;
            mdr_we       = 1'b0;
            pc_we        = 1'b0;
            reg_we       = 1'b0;
            pc_src       = 1'b0;
            alu_src_a    = 2'd0;
            alu_src_b    = 1'b0;
            alu_op       = 2'd0;
            wb_sel       = 2'd0;
            illegal      = 1'b0;
            instr_done   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             instret <= '0;
        else if (instr_done) instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; a narrow instret makes the wrap reachable.
module tb_multicycle_ctrl;
    localparam int IW = 4;

    logic          clk;
    logic          rst;
    logic [31:0]   ir;
    logic          br_taken;
    logic          ir_we, mdr_we, pc_we, reg_we, pc_src, alu_src_b;
    logic [1:0]    alu_src_a, alu_op, wb_sel;
    logic [2:0]    state;
    logic          illegal, instr_done;
    logic [IW-1:0] instret;

    multicycle_ctrl_if mem_if ();

    multicycle_ctrl #(.INSTRET_W(IW)) dut (
        .clk(clk), .rst(rst), .ir(ir), .br_taken(br_taken), .bus(mem_if),
        .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .reg_we(reg_we),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .wb_sel(wb_sel), .state(state), .illegal(illegal),
        .instr_done(instr_done), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [IW-1:0] exp_instret = '0;
    logic [19:0]   f_rdy, f_wait, dec_v, wb_alu;

    // Field order: state, mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, reg_we,
    // pc_src, alu_src_a, alu_src_b, alu_op, wb_sel, illegal, instr_done
    function automatic logic [19:0] pk(input int st, mreq, mwe, asel, irwe, mdrwe, pcwe,
                                       regwe, pcsrc, a, b, op, wb, ill, done);
        return {3'(st), 1'(mreq), 1'(mwe), 1'(asel), 1'(irwe), 1'(mdrwe), 1'(pcwe),
                1'(regwe), 1'(pcsrc), 2'(a), 1'(b), 2'(op), 2'(wb), 1'(ill), 1'(done)};
    endfunction

    function automatic logic [19:0] outs();
        return {state, mem_if.mem_req, mem_if.mem_we, mem_if.addr_sel, ir_we, mdr_we, pc_we,
                reg_we, pc_src, alu_src_a, alu_src_b, alu_op, wb_sel, illegal, instr_done};
    endfunction

    task automatic drive_cycle(input logic rdy, output logic [19:0] obs);
        @(negedge clk);
        mem_if.mem_ready = rdy;
        #1;
        obs = outs();
    endtask

    task automatic test_reset();
        logic [19:0] obs;
        rst = 1'b1; ir = 32'h0; br_taken = 1'b0; mem_if.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        obs = outs();
        n_checks++;
        if (obs !== 20'h0) begin
            n_fail++; $display("[TB] FAIL reset_outputs: got %h expected %h", obs, 20'h0);
        end
        n_checks++;
        if (instret !== '0) begin
            n_fail++; $display("[TB] FAIL reset_instret: got %0d expected 0", instret);
        end
        @(negedge clk);
        mem_if.mem_ready = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (state !== 3'd0 || mem_if.mem_req !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset_release: got state %0d mem_req %b expected 0 1", state, mem_if.mem_req);
        end
    endtask

    task automatic test_add();
        logic [19:0] ev[4];
        logic        rdy[4];
        logic [19:0] obs;
        ir = 32'h002081B3;
        ev  = '{f_rdy, dec_v, pk(2,0,0,0,0,0,0,0,0,0,0,1,0,0,0), wb_alu};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(rdy[i], obs);
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++; $display("[TB] FAIL add_cycle%0d: got %h expected %h", i, obs, ev[i]);
            end
        end
        exp_instret++;
        drive_cycle(1'b0, obs);
        n_checks++;
        if (instret !== exp_instret || obs !== f_wait) begin
            n_fail++; $display("[TB] FAIL add_retire: got instret %0d outs %h expected %0d %h", instret, obs, exp_instret, f_wait);
        end
    endtask

    task automatic test_lw();
        logic [19:0] ev[8];
        logic        rdy[8];
        logic [19:0] obs;
        ir = 32'h0000A103;
        ev = '{f_wait, f_wait, f_rdy, dec_v, pk(2,0,0,0,0,0,0,0,0,0,1,0,0,0,0),
               pk(3,1,0,1,0,0,0,0,0,0,0,0,0,0,0), pk(3,1,0,1,0,1,0,0,0,0,0,0,0,0,0),
               pk(4,0,0,0,0,0,1,1,0,0,0,0,1,0,1)};
        rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive_cycle(rdy[i], obs);
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++; $display("[TB] FAIL lw_cycle%0d: got %h expected %h", i, obs, ev[i]);
            end
        end
        exp_instret++;
        drive_cycle(1'b0, obs);
        n_checks++;
        if (instret !== exp_instret || obs !== f_wait) begin
            n_fail++; $display("[TB] FAIL lw_retire: got instret %0d outs %h expected %0d %h", instret, obs, exp_instret, f_wait);
        end
    endtask

    task automatic test_branch(input logic taken);
        logic [19:0] ev[3];
        logic [19:0] obs;
        ir = 32'h00000463;
        br_taken = taken;
        ev = '{f_rdy, dec_v, pk(2,0,0,0,0,0,1,0,int'(taken),0,0,2,0,0,1)};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(i == 0, obs);
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++; $display("[TB] FAIL beq_taken%0b_cycle%0d: got %h expected %h", taken, i, obs, ev[i]);
            end
        end
        br_taken = 1'b0;
        exp_instret++;
        drive_cycle(1'b0, obs);
        n_checks++;
        if (instret !== exp_instret || obs !== f_wait) begin
            n_fail++; $display("[TB] FAIL beq_retire: got instret %0d outs %h expected %0d %h", instret, obs, exp_instret, f_wait);
        end
    endtask

    task automatic test_jal();
        logic [19:0] ev[3];
        logic [19:0] obs;
        ir = 32'h008000EF;
        ev = '{f_rdy, dec_v, pk(2,0,0,0,0,0,1,1,1,0,0,0,2,0,1)};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(i == 0, obs);
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++; $display("[TB] FAIL jal_cycle%0d: got %h expected %h", i, obs, ev[i]);
            end
        end
        exp_instret++;
        drive_cycle(1'b0, obs);
        n_checks++;
        if (instret !== exp_instret || obs !== f_wait) begin
            n_fail++; $display("[TB] FAIL jal_retire: got instret %0d outs %h expected %0d %h", instret, obs, exp_instret, f_wait);
        end
    endtask

    task automatic test_sw();
        logic [19:0] ev[4];
        logic [19:0] obs;
        ir = 32'h0020A023;
        ev = '{f_rdy, dec_v, pk(2,0,0,0,0,0,0,0,0,0,1,0,0,0,0), pk(3,1,1,1,0,0,1,0,0,0,0,0,0,0,1)};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(i == 0 || i == 3, obs);
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++; $display("[TB] FAIL sw_cycle%0d: got %h expected %h", i, obs, ev[i]);
            end
        end
        exp_instret++;
        drive_cycle(1'b0, obs);
        n_checks++;
        if (instret !== exp_instret || obs !== f_wait) begin
            n_fail++; $display("[TB] FAIL sw_retire: got instret %0d outs %h expected %0d %h", instret, obs, exp_instret, f_wait);
        end
    endtask

    task automatic test_alu_variants();
        logic [31:0] ir_tab[3];
        logic [19:0] ex_tab[3];
        logic [19:0] obs;
        ir_tab = '{32'h000010B7, 32'h00001097, 32'h00508093};
        ex_tab = '{pk(2,0,0,0,0,0,0,0,0,2,1,0,0,0,0), pk(2,0,0,0,0,0,0,0,0,1,1,0,0,0,0),
                   pk(2,0,0,0,0,0,0,0,0,0,1,1,0,0,0)};
        for (int k = 0; k < 3; k++) begin
            ir = ir_tab[k];
            for (int i = 0; i < 4; i++) begin
                drive_cycle(i == 0, obs);
                n_checks++;
                if (obs !== (i == 0 ? f_rdy : i == 1 ? dec_v : i == 2 ? ex_tab[k] : wb_alu)) begin
                    n_fail++; $display("[TB] FAIL alu_op%0d_cycle%0d: got %h", k, i, obs);
                end
            end
            exp_instret++;
        end
        drive_cycle(1'b0, obs);
        n_checks++;
        if (instret !== exp_instret) begin
            n_fail++; $display("[TB] FAIL alu_retire: got instret %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_wrap();
        logic [19:0] obs;
        ir = 32'h00000463;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 3; i++) drive_cycle(i == 0, obs);
            exp_instret++;
            drive_cycle(1'b0, obs);
            n_checks++;
            if (instret !== exp_instret) begin
                n_fail++; $display("[TB] FAIL wrap_step%0d: got instret %0d expected %0d", k, instret, exp_instret);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] ev[4];
        logic [19:0] obs;
        ir = 32'h0020A023;
        ev = '{f_rdy, dec_v, pk(2,0,0,0,0,0,0,0,0,0,1,0,0,0,0), pk(3,1,1,1,0,0,0,0,0,0,0,0,0,0,0)};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(i == 0, obs);
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++; $display("[TB] FAIL swwait_cycle%0d: got %h expected %h", i, obs, ev[i]);
            end
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (outs() !== 20'h0) begin
            n_fail++; $display("[TB] FAIL midreset_outputs: got %h expected %h", outs(), 20'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_if.mem_ready = 1'b0;
        exp_instret = '0;
        @(posedge clk); #1;
        n_checks++;
        if (state !== 3'd0 || mem_if.mem_req !== 1'b1 || instret !== '0) begin
            n_fail++; $display("[TB] FAIL midreset_release: got state %0d mem_req %b instret %0d expected 0 1 0", state, mem_if.mem_req, instret);
        end
    endtask

    task automatic test_trap();
        logic [19:0] obs;
        logic [19:0] trap_v;
        trap_v = pk(5,0,0,0,0,0,0,0,0,0,0,0,0,1,0);
        ir = 32'h0000007F;
        drive_cycle(1'b1, obs);
        drive_cycle(1'b1, obs);
        n_checks++;
        if (obs !== dec_v) begin
            n_fail++; $display("[TB] FAIL trap_decode: got %h expected %h", obs, dec_v);
        end
        for (int i = 0; i < 22; i++) begin
            drive_cycle(1'(i), obs);
            n_checks++;
            if (obs !== trap_v || instret !== exp_instret) begin
                n_fail++; $display("[TB] FAIL trap_hold%0d: got %h instret %0d expected %h %0d", i, obs, instret, trap_v, exp_instret);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (illegal !== 1'b0 || state !== 3'd0) begin
            n_fail++; $display("[TB] FAIL trap_clear: got illegal %b state %0d expected 0 0", illegal, state);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_instret = '0;
    endtask

    initial begin
        f_rdy  = pk(0,1,0,0,1,0,0,0,0,0,0,0,0,0,0);
        f_wait = pk(0,1,0,0,0,0,0,0,0,0,0,0,0,0,0);
        dec_v  = pk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        wb_alu = pk(4,0,0,0,0,0,1,1,0,0,0,0,0,0,1);
        test_reset();
        test_add();
        test_lw();
        test_branch(1'b1);
        test_branch(1'b0);
        test_jal();
        test_sw();
        test_alu_variants();
        test_wrap();
        test_reset_mid();
        test_add();
        test_trap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
